fifo_to_com_tx: RTL and testbench

//  UART transmit path: drains bytes from the shared FIFO and serialises them on tx (8N1, LSB first).

---
 rtl/fifo_to_com_tx_if.sv | 14 +
 rtl/fifo_to_com_tx.sv | 229 ++++++++++++++++++++++
 tb/tb_fifo_to_com_tx.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_to_com_tx_if.sv
// FIFO read port shared between the byte FIFO and the UART transmit path.
// Latency: fifo_data is valid the cycle after fifo_re.
// Backpressure: the reader only strobes fifo_re while !fifo_empty && !fifo_busy.
// Ports: fifo_re (reader -> FIFO); fifo_empty, fifo_busy, fifo_data[7:0] (FIFO -> reader).
// Modports: master = reader (the transmitter), slave = FIFO side.
interface fifo_to_com_tx_if;
  logic       fifo_re;
  logic       fifo_empty;
  logic       fifo_busy;
  logic [7:0] fifo_data;

  modport master (output fifo_re, input fifo_empty, fifo_busy, fifo_data);
  modport slave  (input fifo_re, output fifo_empty, fifo_busy, fifo_data);
endinterface

// File: rtl/fifo_to_com_tx.sv
// fifo_to_com_tx: drains the shared byte FIFO and serialises each byte on tx as 8N1, LSB first,
//   keeping a running CRC-8 (poly 0x07, init 0) and byte count per message; pulses finish on drain.
// Latency: fifo_re -> start-bit edge 2 cycles; frame = (9+STOP_BITS)*CLKS_PER_BIT cycles.
// Backpressure: no read while fifo_busy/fifo_empty or enable low; a frame in flight always completes.
// Optional feature: define APPEND_CRC_EN to send the CRC as one extra 8N1 frame after the FIFO drains.
// Ports: clk, reset (synchronous, active-high), enable (level, gates new frames);
//   fifo (fifo_to_com_tx_if.master): fifo_re out, fifo_empty / fifo_busy / fifo_data[7:0] in;
//   tx (idle high), busy, finish (1-cycle pulse), crc[7:0], sent_count[9:0] out.
module fifo_to_com_tx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  fifo_to_com_tx_if.master fifo,
  output logic             tx,
  output logic             busy,
  output logic             finish,
  output logic [7:0]       crc,
  output logic [9:0]       sent_count
);

  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  // One counter times both a single bit and the whole stop period.
  localparam int CNT_W = $clog2(STOP_CLKS + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    START,
    DATA,
    STOP,
`ifdef APPEND_CRC_EN
    CRC_TX,
`endif
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       crc_q, crc_d;
  logic [9:0]       sent_q, sent_d;
  logic             msg_active_q, msg_active_d;
  logic             tx_q, tx_d;
  logic             fifo_re_q, fifo_re_d;
  logic             busy_q, busy_d;
  logic             finish_q, finish_d;
`ifdef APPEND_CRC_EN
  // Marks that the frame in flight carries the CRC, so its stop bit ends the message.
  logic             crc_frame_q, crc_frame_d;
`endif

  // CRC-8, poly 0x07, MSB first: fold one byte into the running remainder.
  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  // Next-state and datapath.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    crc_d        = crc_q;
    sent_d       = sent_q;
    msg_active_d = msg_active_q;
`ifdef APPEND_CRC_EN
    crc_frame_d  = crc_frame_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (enable && !fifo.fifo_empty && !fifo.fifo_busy) begin
          state_d = READ;
          // First byte of a new message restarts the CRC and the count.
          if (!msg_active_q) begin
            crc_d        = 8'h00;
            sent_d       = 10'd0;
            msg_active_d = 1'b1;
          end
        end else if (msg_active_q && fifo.fifo_empty) begin
          // FIFO drained: close the message even if enable has been dropped.
`ifdef APPEND_CRC_EN
          state_d = CRC_TX;
`else
          state_d = DONE;
`endif
        end
      end

      READ: begin
        state_d = LOAD;
      end

      LOAD: begin
        shift_d = fifo.fifo_data;
        crc_d   = crc8_byte(crc_q, fifo.fifo_data);
        sent_d  = sent_q + 10'd1;
        cnt_d   = '0;
        state_d = START;
      end

      START: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt_q == STOP_LAST) begin
          cnt_d = '0;
`ifdef APPEND_CRC_EN
          state_d = crc_frame_q ? DONE : IDLE;
`else
          state_d = IDLE;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

`ifdef APPEND_CRC_EN
      CRC_TX: begin
        // The CRC frame reuses the byte path; it is neither counted nor folded into crc.
        shift_d     = crc_q;
        crc_frame_d = 1'b1;
        cnt_d       = '0;
        state_d     = START;
      end
`endif

      DONE: begin
        msg_active_d = 1'b0;
`ifdef APPEND_CRC_EN
        crc_frame_d  = 1'b0;
`endif
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so each one lines up exactly
  // with the state it belongs to and never glitches.
  always_comb begin
    tx_d      = 1'b1;
    fifo_re_d = (state_d == READ);
    busy_d    = (state_d != IDLE) && (state_d != DONE);
    finish_d  = (state_d == DONE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      crc_q        <= 8'h00;
      sent_q       <= 10'd0;
      msg_active_q <= 1'b0;
      tx_q         <= 1'b1;
      fifo_re_q    <= 1'b0;
      busy_q       <= 1'b0;
      finish_q     <= 1'b0;
`ifdef APPEND_CRC_EN
      crc_frame_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      crc_q        <= crc_d;
      sent_q       <= sent_d;
      msg_active_q <= msg_active_d;
      tx_q         <= tx_d;
      fifo_re_q    <= fifo_re_d;
      busy_q       <= busy_d;
      finish_q     <= finish_d;
`ifdef APPEND_CRC_EN
      crc_frame_q  <= crc_frame_d;
`endif
    end
  end

  assign fifo.fifo_re = fifo_re_q;
  assign tx           = tx_q;
  assign busy         = busy_q;
  assign finish       = finish_q;
  assign crc          = crc_q;
  assign sent_count   = sent_q;

endmodule

// File: tb/tb_fifo_to_com_tx.sv
// Bench for fifo_to_com_tx: FIFO model, UART line decoder and CRC reference
// (polynomial long division), single-byte vector table, hand-written corner
// sequences and randomized messages.
module tb_fifo_to_com_tx;
  localparam int CPB = 4;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_crc;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       tx;
  logic       busy;
  logic       finish;
  logic [7:0] crc;
  logic [9:0] sent_count;

  fifo_to_com_tx_if fif ();

  fifo_to_com_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo       (fif),
    .tx         (tx),
    .busy       (busy),
    .finish     (finish),
    .crc        (crc),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CRC as remainder of M(x)*x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] ref_crc(input bq_t m);
    logic       bits[$];
    logic [7:0] b;
    logic [8:0] rem;
    foreach (m[i]) begin
      b = m[i];
      for (int k = 7; k >= 0; k--) bits.push_back(b[k]);
    end
    repeat (8) bits.push_back(1'b0);
    rem = 9'd0;
    foreach (bits[i]) begin
      rem = {rem[7:0], bits[i]};
      if (rem[8]) rem = rem ^ 9'h107;
    end
    return rem[7:0];
  endfunction

  // FIFO model: pops on the strobe, data valid from the next edge onward.
  bq_t fq;
  int  underflow = 0;
  always @(negedge clk) begin
    if (fif.fifo_re === 1'b1) begin
      if (fq.size() > 0) fif.fifo_data = fq.pop_front();
      else underflow++;
    end
    fif.fifo_empty = (fq.size() == 0);
  end

  // UART decoder: samples the middle of each bit.
  bq_t        rxq;
  int         frames_started = 0;
  int         frame_err = 0;
  int         fin_count = 0;
  bit         dec_on = 1'b0;
  int         dec_idx = 0;
  logic [7:0] dec_byte;
  always @(negedge clk) begin
    if (finish === 1'b1) fin_count++;
    if (reset === 1'b1) begin
      dec_on = 1'b0;
    end else if (!dec_on) begin
      if (tx === 1'b0) begin
        dec_on = 1'b1;
        dec_idx = 0;
        frames_started++;
      end
    end else begin
      dec_idx++;
      if (dec_idx == CPB / 2 && tx !== 1'b0) frame_err++;
      if (dec_idx >= CPB && dec_idx < 9 * CPB && dec_idx % CPB == CPB / 2)
        dec_byte[dec_idx / CPB - 1] = tx;
      if (dec_idx == 9 * CPB + CPB / 2) begin
        if (tx !== 1'b1) frame_err++;
        rxq.push_back(dec_byte);
        dec_on = 1'b0;
      end
    end
  end

  task automatic finish_and_check(input bq_t m, input logic [7:0] exp_crc, input string tag);
    bq_t exp;
    int  t;
    int  bad;
    exp = m;
`ifdef APPEND_CRC_EN
    exp.push_back(exp_crc);
`endif
    t = 0;
    while (finish !== 1'b1 && t < 60 * (m.size() + 3)) begin
      @(negedge clk);
      t++;
    end
    check({tag, " finish"}, finish, 1);
    check({tag, " rx count"}, rxq.size(), exp.size());
    bad = 0;
    foreach (exp[i]) if (i >= rxq.size() || rxq[i] !== exp[i]) bad++;
    check({tag, " rx data"}, bad, 0);
    check({tag, " crc"}, crc, exp_crc);
    check({tag, " sent_count"}, sent_count, m.size());
    @(negedge clk);
    check({tag, " finish one cycle"}, finish, 0);
  endtask

  task automatic send_msg(input bq_t m, input logic [7:0] exp_crc, input string tag);
    rxq.delete();
    foreach (m[i]) fq.push_back(m[i]);
    enable = 1'b1;
    finish_and_check(m, exp_crc, tag);
  endtask

  initial begin
    vec_t       vecs[5];
    bq_t        m;
    int         t;
    int         bad;
    int         bbad;
    int         fin_at;
    int         fc0;
    int         f0;
    logic [7:0] a5;
    logic       exp_bit;

    vecs[0] = '{8'h00, 8'h00};
    vecs[1] = '{8'h01, 8'h07};
    vecs[2] = '{8'h80, 8'h89};
    vecs[3] = '{8'hA5, 8'h72};
    vecs[4] = '{8'hFF, 8'hF3};

    reset = 1'b1;
    enable = 1'b0;
    fif.fifo_empty = 1'b1;
    fif.fifo_busy = 1'b0;
    fif.fifo_data = 8'h00;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset tx", tx, 1);
    check("reset fifo_re", fif.fifo_re, 0);
    check("reset busy", busy, 0);
    check("reset finish", finish, 0);
    check("reset crc", crc, 0);
    check("reset sent_count", sent_count, 0);
    reset = 1'b0;

    // Empty FIFO with enable high: line stays idle.
    enable = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || fif.fifo_re !== 1'b0 || busy !== 1'b0 || finish !== 1'b0) bad++;
    end
    check("idle empty fifo", bad, 0);

    // Single-byte vector table.
    for (int v = 0; v < 5; v++) begin
      m.delete();
      m.push_back(vecs[v].data);
      send_msg(m, vecs[v].exp_crc, $sformatf("vec%0d", v));
    end

    // Exact waveform, busy window and finish timing for 0xA5.
    a5 = 8'hA5;
    rxq.delete();
    fq.push_back(a5);
    t = 0;
    while (fif.fifo_re !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("a5 fifo_re", fif.fifo_re, 1);
    @(negedge clk);
    check("a5 load tx high", tx, 1);
    bad = 0;
    bbad = 0;
    fin_at = -1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      exp_bit = (i < CPB) ? 1'b0 : (i < 9 * CPB) ? a5[i / CPB - 1] : 1'b1;
      if (i < 10 * CPB && tx !== exp_bit) bad++;
      if (i < 10 * CPB && busy !== 1'b1) bbad++;
      if (i == 10 * CPB && busy !== 1'b0) bbad++;
      if (finish === 1'b1 && fin_at < 0) fin_at = i;
    end
    check("a5 tx waveform", bad, 0);
    check("a5 busy window", bbad, 0);
`ifdef APPEND_CRC_EN
    check("a5 finish time", fin_at, 20 * CPB + 2);
`else
    check("a5 finish time", fin_at, 10 * CPB + 1);
`endif
    check("a5 crc", crc, ref_crc(rxq[0:0]));
    check("a5 sent_count", sent_count, 1);

    // fifo_busy holds off the read.
    rxq.delete();
    fif.fifo_busy = 1'b1;
    fq.push_back(8'h3C);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (fif.fifo_re !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("fifo_busy no read", bad, 0);
    fif.fifo_busy = 1'b0;
    @(negedge clk);
    check("busy release fifo_re", fif.fifo_re, 1);
    @(negedge clk);
    check("busy release tx load", tx, 1);
    @(negedge clk);
    check("busy release start bit", tx, 0);
    m.delete();
    m.push_back(8'h3C);
    finish_and_check(m, ref_crc(m), "busy release");

    // Standard check string; also confirms crc holds after finish.
    m.delete();
    for (int i = 0; i < 9; i++) m.push_back(8'h31 + 8'(i));
    send_msg(m, 8'hF4, "check123");
    repeat (10) @(negedge clk);
    check("crc hold", crc, 8'hF4);
    check("count hold", sent_count, 9);

    // Reset during DATA bit 3 aborts; the next bytes go out as a new message.
    rxq.delete();
    m.delete();
    for (int i = 0; i < 3; i++) m.push_back(8'($urandom));
    f0 = frames_started;
    foreach (m[i]) fq.push_back(m[i]);
    enable = 1'b1;
    t = 0;
    while (frames_started == f0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("abort frame started", frames_started, f0 + 1);
    repeat (4 * CPB + 1) @(negedge clk);
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    check("abort tx", tx, 1);
    check("abort busy", busy, 0);
    check("abort crc", crc, 0);
    check("abort sent_count", sent_count, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("abort fifo left", fq.size(), 2);
    void'(m.pop_front());
    enable = 1'b1;
    finish_and_check(m, ref_crc(m), "after abort");

    // enable dropped in START of byte 2 of 3.
    rxq.delete();
    m.delete();
    for (int i = 0; i < 3; i++) m.push_back(8'($urandom));
    f0 = frames_started;
    fc0 = fin_count;
    foreach (m[i]) fq.push_back(m[i]);
    enable = 1'b1;
    t = 0;
    while (frames_started < f0 + 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("endrop second frame", frames_started, f0 + 2);
    enable = 1'b0;
    t = 0;
    while (busy !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (20) @(negedge clk);
    check("endrop busy low", busy, 0);
    check("endrop rx count", rxq.size(), 2);
    check("endrop fifo left", fq.size(), 1);
    check("endrop no finish", fin_count, fc0);
    check("endrop sent_count", sent_count, 2);
    enable = 1'b1;
    finish_and_check(m, ref_crc(m), "endrop resume");

    // Randomized messages against the reference model.
    for (int r = 0; r < 6; r++) begin
      m.delete();
      repeat ($urandom_range(1, 6)) m.push_back(8'($urandom));
      send_msg(m, ref_crc(m), $sformatf("rand%0d", r));
    end

    check("fifo underflow", underflow, 0);
    check("framing errors", frame_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
